// File: rtl/multi_mole_game_ctrl.sv
// Whack-a-mole engine: up to MAX_MOLES moles over NUM_HOLES holes, LFSR placement, score/misses/lives.
// All events resolve in one clock; mole_map follows slot registers (one cycle after a spawn or hit); no backpressure.
module multi_mole_game_ctrl #(
  parameter int          NUM_HOLES    = 18,
  parameter int          MAX_MOLES    = 3,
  parameter int          BASE_LIFE_MS = 2000,
  parameter int          SPAWN_MS     = 800,
  parameter int          COUNTDOWN_MS = 3000,
  parameter int          LIVES        = 3,
  parameter int          SCORE_W      = 12,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         CD_W         = $clog2(COUNTDOWN_MS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ms_tick,
  input  logic                 start,
  input  logic [1:0]           difficulty,
  input  logic [NUM_HOLES-1:0] hammer,
  output logic [NUM_HOLES-1:0] mole_map,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [3:0]           lives,
  output logic [CD_W-1:0]      countdown_ms,
  output logic [1:0]           state,
  output logic                 game_over
);
  localparam int HOLE_W = $clog2(NUM_HOLES);
  localparam int LIFE_W = $clog2(BASE_LIFE_MS + 1);
  localparam int SPW    = $clog2(SPAWN_MS + 1);
  localparam int SUM_W  = SCORE_W + 6;
  localparam logic [HOLE_W:0]  NH_L = (HOLE_W + 1)'(NUM_HOLES);
  localparam logic [SUM_W-1:0] SAT  = SUM_W'({SCORE_W{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PLAY, S_OVER} state_t;
  state_t st, st_nxt;

  logic                 start_q, start_edge;
  logic [NUM_HOLES-1:0] hammer_q, edges, lit, hit_map, miss_map, blocked;
  logic [15:0]          lfsr;
  logic [1:0]           diff_q;
  logic [CD_W-1:0]      cd_q;
  logic [SPW-1:0]       spawn_cnt;
  logic [SCORE_W-1:0]   score_q, misses_q, score_nxt, misses_nxt;
  logic [SUM_W-1:0]     score_sum, misses_sum;
  logic [3:0]           lives_q, lives_nxt;
  logic [MAX_MOLES-1:0] slot_vld, hit_slot, exp_slot, free_slot, spawn_sel;
  logic [HOLE_W-1:0]    slot_hole [MAX_MOLES];
  logic [LIFE_W-1:0]    slot_life [MAX_MOLES];
  logic [HOLE_W-1:0]    cand;
  logic [LIFE_W-1:0]    life_val;
  logic                 spawn_wrap, spawn_ok, found;
  int                   n_hit, n_miss, n_exp, n_occ, spawn_lim, active_limit;

  assign start_edge = start & ~start_q;

  always_comb begin
    lit = '0;
    for (int i = 0; i < MAX_MOLES; i++)
      if (slot_vld[i]) lit[slot_hole[i]] = 1'b1;
  end

  // LFSR low bits span at most 2*NUM_HOLES-1, so a single fold lands in range.
  always_comb begin
    cand = lfsr[HOLE_W-1:0];
    if ({1'b0, lfsr[HOLE_W-1:0]} >= NH_L)
      cand = HOLE_W'({1'b0, lfsr[HOLE_W-1:0]} - NH_L);
  end

  always_comb begin
    edges        = hammer & ~hammer_q;
    hit_map      = edges & lit;
    miss_map     = edges & ~lit;
    n_hit        = $countones(hit_map);
    n_miss       = $countones(miss_map);
    life_val     = LIFE_W'(BASE_LIFE_MS >> diff_q);
    spawn_lim    = SPAWN_MS >> diff_q;
    active_limit = (int'(diff_q) + 1 < MAX_MOLES) ? int'(diff_q) + 1 : MAX_MOLES;
    blocked      = lit;
    n_exp        = 0;
    n_occ        = 0;
    found        = 1'b0;
    spawn_sel    = '0;
    for (int i = 0; i < MAX_MOLES; i++) begin
      hit_slot[i]  = slot_vld[i] & hit_map[slot_hole[i]];
      exp_slot[i]  = slot_vld[i] & ~hit_slot[i] & ms_tick & (slot_life[i] <= LIFE_W'(1));
      free_slot[i] = ~slot_vld[i] | exp_slot[i];
      if (exp_slot[i]) begin
        n_exp++;
        blocked[slot_hole[i]] = 1'b0;
      end
      if (!free_slot[i]) n_occ++;
    end
    for (int i = 0; i < MAX_MOLES; i++)
      if (free_slot[i] && !found) begin
        spawn_sel[i] = 1'b1;
        found        = 1'b1;
      end
    // Expiries are already removed from occupancy and blocking; hit slots still count.
    spawn_wrap = ms_tick && (int'(spawn_cnt) + 1 >= spawn_lim);
    spawn_ok   = spawn_wrap && (n_occ < active_limit) && found && !blocked[cand];
    score_sum  = SUM_W'(score_q) + SUM_W'(n_hit);
    misses_sum = SUM_W'(misses_q) + SUM_W'(n_miss);
    score_nxt  = (score_sum > SAT) ? SAT[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
    misses_nxt = (misses_sum > SAT) ? SAT[SCORE_W-1:0] : misses_sum[SCORE_W-1:0];
    lives_nxt  = (int'(lives_q) > n_exp) ? 4'(int'(lives_q) - n_exp) : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) st <= S_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE, S_OVER: if (start_edge) st_nxt = S_COUNT;
      S_COUNT:        if (ms_tick && cd_q <= CD_W'(1)) st_nxt = S_PLAY;
      S_PLAY:         if (lives_nxt == 4'd0) st_nxt = S_OVER;
      default:        st_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    state        = st;
    game_over    = (st == S_OVER);
    mole_map     = (st == S_PLAY) ? lit : '0;
    score        = score_q;
    misses       = misses_q;
    lives        = lives_q;
    countdown_ms = cd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= start;
      hammer_q  <= hammer;
      lfsr      <= LFSR_SEED;
      diff_q    <= 2'd0;
      cd_q      <= '0;
      spawn_cnt <= '0;
      score_q   <= '0;
      misses_q  <= '0;
      lives_q   <= 4'(LIVES);
      slot_vld  <= '0;
      for (int i = 0; i < MAX_MOLES; i++) begin
        slot_hole[i] <= '0;
        slot_life[i] <= '0;
      end
    end else begin
      start_q  <= start;
      hammer_q <= hammer;
      lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      unique case (st)
        S_IDLE, S_OVER: begin
          if (start_edge) begin
            diff_q    <= difficulty;
            cd_q      <= CD_W'(COUNTDOWN_MS);
            score_q   <= '0;
            misses_q  <= '0;
            lives_q   <= 4'(LIVES);
            slot_vld  <= '0;
            spawn_cnt <= '0;
          end
        end
        S_COUNT: begin
          if (ms_tick && cd_q != '0) cd_q <= cd_q - 1'b1;
        end
        S_PLAY: begin
          score_q  <= score_nxt;
          misses_q <= misses_nxt;
          lives_q  <= lives_nxt;
          if (ms_tick) spawn_cnt <= spawn_wrap ? '0 : spawn_cnt + 1'b1;
          for (int i = 0; i < MAX_MOLES; i++) begin
            if (hit_slot[i] || exp_slot[i]) slot_vld[i] <= 1'b0;
            else if (ms_tick && slot_vld[i]) slot_life[i] <= slot_life[i] - 1'b1;
            if (spawn_ok && spawn_sel[i]) begin
              slot_vld[i]  <= 1'b1;
              slot_hole[i] <= cand;
              slot_life[i] <= life_val;
            end
          end
          if (lives_nxt == 4'd0) slot_vld <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_mole_game_ctrl.sv
// Randomized game play against a slot-list reference model of the mole game rules.
module tb_multi_mole_game_ctrl;
  localparam int NH = 8, MM = 2, BL = 40, SP = 10, CD = 20, LV = 3, SW = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int CDW  = $clog2(CD + 1);
  localparam int HW   = $clog2(NH);
  localparam int SMAX = (1 << SW) - 1;
  localparam int NCYC = 40000;

  logic          clk = 1'b0, reset = 1'b1, ms_tick = 1'b0, start = 1'b0;
  logic [1:0]    difficulty = 2'd0;
  logic [NH-1:0] hammer = '0;
  logic [NH-1:0] mole_map;
  logic [SW-1:0] score, misses;
  logic [3:0]    lives;
  logic [CDW-1:0] countdown_ms;
  logic [1:0]    state;
  logic          game_over;

  multi_mole_game_ctrl #(
    .NUM_HOLES(NH), .MAX_MOLES(MM), .BASE_LIFE_MS(BL), .SPAWN_MS(SP),
    .COUNTDOWN_MS(CD), .LIVES(LV), .SCORE_W(SW), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .ms_tick(ms_tick), .start(start), .difficulty(difficulty),
    .hammer(hammer), .mole_map(mole_map), .score(score), .misses(misses), .lives(lives),
    .countdown_ms(countdown_ms), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: game phase 0 idle, 1 countdown, 2 play, 3 over.
  int            m_st, m_cd, m_score, m_miss, m_lives, m_diff, m_spcnt;
  bit            m_on [MM];
  int            m_hole [MM];
  int            m_left [MM];
  bit            m_sq;
  logic [NH-1:0] m_hq;
  logic [15:0]   m_lfsr;

  function automatic logic [NH-1:0] model_lit();
    logic [NH-1:0] r = '0;
    for (int i = 0; i < MM; i++) if (m_on[i]) r[m_hole[i]] = 1'b1;
    return r;
  endfunction

  task automatic play_step(input logic [NH-1:0] edges, input bit tk, input int cand);
    logic [NH-1:0] lit, hits, blk;
    bit hit_s [MM];
    int nexp, life, spawn, lim, occ, slot;
    bit attempt;
    lit   = model_lit();
    hits  = edges & lit;
    m_score = (m_score + $countones(hits) > SMAX) ? SMAX : m_score + $countones(hits);
    m_miss  = (m_miss + $countones(edges & ~lit) > SMAX) ? SMAX : m_miss + $countones(edges & ~lit);
    life  = BL >> m_diff;
    spawn = SP >> m_diff;
    lim   = (m_diff + 1 < MM) ? m_diff + 1 : MM;
    nexp  = 0;
    for (int i = 0; i < MM; i++) begin
      hit_s[i] = m_on[i] && hits[m_hole[i]];
      if (m_on[i] && !hit_s[i] && tk) begin
        m_left[i]--;
        if (m_left[i] <= 0) begin m_on[i] = 0; nexp++; end
      end
    end
    m_lives = (m_lives - nexp < 0) ? 0 : m_lives - nexp;
    attempt = 0;
    if (tk) begin
      if (m_spcnt + 1 >= spawn) begin m_spcnt = 0; attempt = 1; end
      else m_spcnt++;
    end
    if (attempt) begin
      occ = 0; slot = -1;
      for (int i = 0; i < MM; i++) begin
        if (m_on[i]) occ++;
        else if (slot < 0) slot = i;
      end
      blk = model_lit();
      if (occ < lim && slot >= 0 && !blk[cand]) begin
        m_on[slot] = 1; m_hole[slot] = cand; m_left[slot] = life;
      end
    end
    for (int i = 0; i < MM; i++) if (hit_s[i]) m_on[i] = 0;
    if (m_lives == 0) begin
      m_st = 3;
      for (int i = 0; i < MM; i++) m_on[i] = 0;
    end
  endtask

  task automatic model_step(input bit rst, input bit st_in, input bit tk, input logic [NH-1:0] hm, input int df);
    int cand;
    bit sedge, fb;
    logic [NH-1:0] edges;
    if (rst) begin
      m_st = 0; m_cd = 0; m_score = 0; m_miss = 0; m_lives = LV; m_diff = 0; m_spcnt = 0;
      for (int i = 0; i < MM; i++) m_on[i] = 0;
      m_sq = st_in; m_hq = hm; m_lfsr = SEED;
      return;
    end
    cand  = (int'(m_lfsr) & ((1 << HW) - 1)) % NH;
    sedge = st_in && !m_sq;
    edges = hm & ~m_hq;
    m_sq  = st_in;
    m_hq  = hm;
    fb = m_lfsr[0];
    m_lfsr = m_lfsr >> 1;
    if (fb) m_lfsr = m_lfsr ^ 16'hB400;
    case (m_st)
      0, 3: if (sedge) begin
        m_st = 1; m_diff = df; m_cd = CD; m_score = 0; m_miss = 0; m_lives = LV; m_spcnt = 0;
        for (int i = 0; i < MM; i++) m_on[i] = 0;
      end
      1: if (tk) begin
        m_cd--;
        if (m_cd == 0) m_st = 2;
      end
      default: play_step(edges, tk, cand);
    endcase
  endtask

  bit chk_rst, chk_cd, mid_rst_done;
  int games, cur_mode, next_diff, game_cyc, prev, mode_eff;
  logic [NH-1:0] h, lit_now;

  task automatic compare_outputs();
    logic [NH-1:0] exp_map;
    int lim;
    exp_map = (m_st == 2) ? model_lit() : '0;
    check("state", int'(state), m_st);
    check("mole_map", int'(mole_map), int'(exp_map));
    check("score", int'(score), m_score);
    check("misses", int'(misses), m_miss);
    check("lives", int'(lives), m_lives);
    check("countdown_ms", int'(countdown_ms), (m_st == 1) ? m_cd : 0);
    check("game_over", int'(game_over), int'(m_st == 3));
    if (m_st == 2) begin
      lim = (m_diff + 1 < MM) ? m_diff + 1 : MM;
      check("mole_count_within_limit", int'($countones(mole_map) <= lim), 1);
    end
    if (chk_rst) begin
      check("reset_state", int'(state), 0);
      check("reset_mole_map", int'(mole_map), 0);
      check("reset_lives", int'(lives), LV);
      check("reset_score", int'(score), 0);
    end
    if (chk_cd) begin
      check("countdown_load", int'(countdown_ms), CD);
      check("countdown_state", int'(state), 1);
      check("countdown_lives", int'(lives), LV);
      check("countdown_score", int'(score), 0);
    end
  endtask

  task automatic drive_hammer();
    h = hammer;
    for (int b = 0; b < NH; b++) if (h[b] && $urandom_range(0, 1) == 1) h[b] = 1'b0;
    lit_now  = (m_st == 2) ? model_lit() : '0;
    mode_eff = (game_cyc > 2500) ? 0 : cur_mode;
    case (mode_eff)
      1: begin
        for (int i = 0; i < MM; i++)
          if (ms_tick && m_on[i] && m_left[i] == 1 && $urandom_range(0, 1) == 1) h[m_hole[i]] = 1'b1;
        for (int b = 0; b < NH; b++) if (lit_now[b] && $urandom_range(0, 5) == 0) h[b] = 1'b1;
        if ($urandom_range(0, 30) == 0) h[$urandom_range(0, NH - 1)] = 1'b1;
      end
      2: for (int b = 0; b < NH; b++) if ($urandom_range(0, 9) == 0) h[b] = 1'b1;
      default: h = '0;
    endcase
    hammer = h;
  endtask

  initial begin
    games = 0; cur_mode = 0; next_diff = 0; game_cyc = 0; mid_rst_done = 0; chk_cd = 0;
    model_step(1'b1, 1'b0, 1'b0, '0, 0);
    chk_rst = 1;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      compare_outputs();
      ms_tick = (c % 4 == 3);
      reset   = (c < 2);
      if (!mid_rst_done && games >= 2 && m_st == 2 && $countones(model_lit()) == 2) begin
        reset = 1'b1;
        mid_rst_done = 1;
      end
      chk_rst = reset;
      start = (m_st == 0 || m_st == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
      difficulty = next_diff[1:0];
      drive_hammer();
      prev = m_st;
      model_step(reset, start, ms_tick, hammer, int'(difficulty));
      chk_cd = (m_st == 1 && prev != 1);
      if (chk_cd) begin
        cur_mode  = (games == 0) ? 0 : (games == 1) ? 1 : int'($urandom_range(0, 2));
        games++;
        next_diff = (games == 1) ? 1 : int'($urandom_range(0, 3));
        game_cyc  = 0;
      end else begin
        game_cyc++;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
